// File: rtl/matmul_sequencer.sv
// Matmul sequencer: fetches A columns / B rows, streams them into the PE
// array, waits out the systolic skew and writes result rows to scratchpad.
module matmul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] OPA_BASE = 32'h20,
  parameter logic [ADDR_WIDTH-1:0] OPB_BASE = 32'h40,
  parameter logic [ADDR_WIDTH-1:0] SP_BASE  = 32'h60
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_bit_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            k_dim_i,
  input  logic [1:0]            m_dim_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  output logic                  pe_clear_o,
  output logic                  pe_valid_o,
  output logic [BUS_WIDTH-1:0]  pe_a_o,
  output logic [BUS_WIDTH-1:0]  pe_b_o,
  output logic [1:0]            res_row_o,
  input  logic [BUS_WIDTH-1:0]  res_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  clear_start_o,
  output logic                  err_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int STRIDE  = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    DRAIN,
    WRITEBACK,
    DONE
  } state_t;

  state_t               state;
  logic                 start_q;
  logic [1:0]           n_q;
  logic [1:0]           k_q;
  logic [1:0]           m_q;
  logic [1:0]           k_cnt;
  logic [1:0]           row_cnt;
  logic [2:0]           drain_cnt;
  logic                 a_pend;
  logic                 b_pend;
  logic [BUS_WIDTH-1:0] a_hold;

  logic start_edge;
  logic legal;
  logic gnt;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [1:0]            idx
  );
    return base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(STRIDE);
  endfunction

  function automatic logic dim_ok(input logic [1:0] d);
    return (d != 2'd0) && (int'(d) <= MAX_DIM);
  endfunction

  assign start_edge = start_bit_i && !start_q;
  assign legal = dim_ok(n_dim_i) && dim_ok(k_dim_i)
              && dim_ok(m_dim_i);
  assign gnt = mem_req_o && mem_gnt_i;

  // Write data tracks the PE row selected by the registered res_row_o.
  assign mem_wdata_o = mem_we_o ? res_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      n_q           <= '0;
      k_q           <= '0;
      m_q           <= '0;
      k_cnt         <= '0;
      row_cnt       <= '0;
      drain_cnt     <= '0;
      a_pend        <= 1'b0;
      b_pend        <= 1'b0;
      a_hold        <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      pe_clear_o    <= 1'b0;
      pe_valid_o    <= 1'b0;
      pe_a_o        <= '0;
      pe_b_o        <= '0;
      res_row_o     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      clear_start_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      start_q       <= start_bit_i;
      pe_clear_o    <= 1'b0;
      pe_valid_o    <= 1'b0;
      pe_a_o        <= '0;
      pe_b_o        <= '0;
      done_o        <= 1'b0;
      clear_start_o <= 1'b0;
      a_pend        <= 1'b0;
      b_pend        <= 1'b0;

      // Read data lands one cycle after its grant.
      if (a_pend) begin
        a_hold <= mem_rdata_i;
      end
      if (b_pend) begin
        pe_valid_o <= 1'b1;
        pe_a_o     <= a_hold;
        pe_b_o     <= mem_rdata_i;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            n_q     <= n_dim_i;
            k_q     <= k_dim_i;
            m_q     <= m_dim_i;
            k_cnt   <= '0;
            row_cnt <= '0;
            busy_o  <= 1'b1;
            if (legal) begin
              err_o      <= 1'b0;
              state      <= FETCH_A;
              pe_clear_o <= 1'b1;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= word_addr(OPA_BASE, 2'd0);
            end else begin
              err_o         <= 1'b1;
              state         <= DONE;
              done_o        <= 1'b1;
              clear_start_o <= 1'b1;
            end
          end
        end
        FETCH_A: begin
          if (gnt) begin
            a_pend     <= 1'b1;
            state      <= FETCH_B;
            mem_addr_o <= word_addr(OPB_BASE, k_cnt);
          end
        end
        FETCH_B: begin
          if (gnt) begin
            b_pend <= 1'b1;
            if (k_cnt == k_q - 2'd1) begin
              // Two extra cycles cover the last B beat and its PE pulse.
              state      <= DRAIN;
              mem_req_o  <= 1'b0;
              mem_addr_o <= '0;
              drain_cnt  <= 3'(n_q) + 3'(m_q) + 3'd1;
            end else begin
              k_cnt      <= k_cnt + 2'd1;
              state      <= FETCH_A;
              mem_addr_o <= word_addr(OPA_BASE, k_cnt + 2'd1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd1) begin
            state      <= WRITEBACK;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b1;
            mem_addr_o <= word_addr(SP_BASE, 2'd0);
            res_row_o  <= '0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        WRITEBACK: begin
          if (gnt) begin
            if (row_cnt == n_q - 2'd1) begin
              state         <= DONE;
              mem_req_o     <= 1'b0;
              mem_we_o      <= 1'b0;
              mem_addr_o    <= '0;
              res_row_o     <= '0;
              done_o        <= 1'b1;
              clear_start_o <= 1'b1;
            end else begin
              row_cnt    <= row_cnt + 2'd1;
              res_row_o  <= row_cnt + 2'd1;
              mem_addr_o <= word_addr(SP_BASE, row_cnt + 2'd1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, element width; BUS_WIDTH, 64, memory word width; ADDR_WIDTH, 32, address width; OPA_BASE, 32'h20, operand A base; OPB_BASE, 32'h40, operand B base; SP_BASE, 32'h60, result scratchpad base.
REQ-002 Derived constants SHALL be MAX_DIM = BUS_WIDTH/DATA_WIDTH and STRIDE = BUS_WIDTH/8 bytes per word.
REQ-003 Ports SHALL be, in order (name  direction  width  meaning): clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset; start_bit_i  in  1  control-register start bit; n_dim_i, k_dim_i, m_dim_i  in  2 each  matrix dimensions (A is N x K, B is K x M).
REQ-004 Memory-side ports SHALL be: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  BUS_WIDTH; mem_gnt_i  in  1  grant from the bus/APB arbiter; mem_rdata_i  in  BUS_WIDTH  read data, valid the cycle after grant.
REQ-005 PE-array ports SHALL be: pe_clear_o  out  1; pe_valid_o  out  1; pe_a_o  out  BUS_WIDTH; pe_b_o  out  BUS_WIDTH; res_row_o  out  2  result row select; res_data_i  in  BUS_WIDTH  selected result row.
REQ-006 Status ports SHALL be: busy_o  out  1; done_o  out  1; clear_start_o  out  1; err_o  out  1.
REQ-007 The design SHALL have one clock, clk_i; reset is synchronous and active-high on rst_i.

Function
REQ-008 The FSM SHALL have the states IDLE, FETCH_A, FETCH_B, DRAIN, WRITEBACK and DONE.
REQ-009 A start SHALL be a rising edge of start_bit_i (start_bit_i=1 and the registered previous value=0) sampled in IDLE; levels and edges outside IDLE SHALL be ignored.
REQ-010 On start, dimensions SHALL be latched, and the run is legal only if every dimension is in 1..MAX_DIM.
REQ-011 On a start with illegal dimensions, the FSM SHALL go to DONE without memory access, and err_o SHALL be set.
REQ-012 err_o SHALL be sticky until the next accepted start.
REQ-013 On a legal start, err_o SHALL clear and the FSM SHALL enter FETCH_A with pe_clear_o=1 for exactly that first FETCH_A cycle.
REQ-014 For k = 0..K-1, FETCH_A SHALL read OPA_BASE + k*STRIDE (column k of A) and FETCH_B SHALL read OPB_BASE + k*STRIDE (row k of B), with mem_we_o=0.
REQ-015 mem_req_o, mem_addr_o and mem_wdata_o SHALL be held stable until the cycle mem_gnt_i=1.
REQ-016 The FSM SHALL advance only on grant; requests SHALL be issued back-to-back when mem_gnt_i stays high.
REQ-017 A read data SHALL be captured into a holding register the cycle after the A grant.
REQ-018 The cycle after the B data returns, pe_valid_o SHALL be 1 for one cycle, with pe_a_o = held A and pe_b_o = B data.
REQ-019 Exactly K pe_valid_o pulses SHALL occur per legal run, in k order.
REQ-020 pe_a_o and pe_b_o SHALL be 0 whenever pe_valid_o=0.
REQ-021 DRAIN SHALL start after the K-th pe_valid_o and last exactly N+M-1 cycles (systolic skew), using a cycle counter.
REQ-022 In WRITEBACK, for i = 0..N-1, the block SHALL drive res_row_o=i, mem_we_o=1, mem_addr_o=SP_BASE+i*STRIDE and mem_wdata_o=res_data_i, each held until grant.
REQ-023 DONE SHALL last one cycle with done_o=1 and clear_start_o=1, then the FSM SHALL return to IDLE.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 mem_gnt_i asserted while mem_req_o=0 SHALL be ignored.
REQ-026 start_bit_i falling mid-run SHALL NOT abort the run.
REQ-027 A stale start_bit_i still high on return to IDLE SHALL NOT retrigger a run.
REQ-028 Dimension inputs changing mid-run SHALL have no effect (latched values are used).

Reset
REQ-029 With rst_i=1 at a clk_i edge, the block SHALL go to IDLE and clear all counters, the holding register and the registered start_bit_i value.
REQ-030 During reset, all outputs SHALL be 0: busy_o, done_o, clear_start_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, pe_clear_o, pe_valid_o, pe_a_o, pe_b_o and res_row_o.
REQ-031 Reset mid-run SHALL abandon the run without a done_o pulse; a pending request SHALL be dropped the cycle after reset.

Verification
REQ-032 Scenario: N=K=M=2, mem_gnt_i=1 -> reads at 0x20, 0x40, 0x28, 0x48; 2 pe_valid_o pulses; DRAIN for 3 cycles; writes at 0x60, 0x68; single done_o and clear_start_o pulse; err_o=0.
REQ-033 Scenario: grant withheld 3 cycles on the first B read -> mem_addr_o stays 0x40 with mem_req_o=1; pe_valid_o is delayed by exactly 3 cycles.
REQ-034 Scenario: k_dim_i=0 or n_dim_i=3 (MAX_DIM=2) -> no mem_req_o; DONE the cycle after the start; err_o=1 until the next legal start.
REQ-035 Scenario: start_bit_i held high through DONE and two further cycles -> exactly one run; busy_o=0 afterwards.
REQ-036 Scenario: rst_i pulsed during WRITEBACK -> next cycle all outputs 0 and IDLE; a new start edge runs normally.
REQ-037 Scenario: N=1, K=2, M=1 -> DRAIN lasts 1 cycle; one write at 0x60 with res_row_o=0.
